// File: rtl/arcade_input_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : arcade_input_pkg                                              |
// | Purpose  : Shared constants and types for the arcade input router:       |
// |            joystick direction bit positions, the coin FSM state type     |
// |            and the coin queue depth.                                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package arcade_input_pkg;

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;

  localparam int QUEUE_MAX = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

endpackage
`default_nettype wire

// File: rtl/coin_pulser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : coin_pulser                                                   |
// | Purpose  : Queues coin insert edges (saturating at QUEUE_MAX) and plays  |
// |            them out as fixed-width pulses separated by equal low gaps.   |
// | Ports    : clk       in  system clock                                    |
// |            reset     in  asynchronous active-high reset                  |
// |            edge_cnt  in  coin edges seen this cycle (0..3)               |
// |            coin      out shaped coin pulse                               |
// |            pending   out coins queued, not yet pulsed                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter logic [15:0] COIN_PULSE = 16'd4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] edge_cnt,
  output logic       coin,
  output logic [1:0] pending
);

  localparam int            CW       = (COIN_PULSE > 16'd1) ? $clog2(COIN_PULSE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(COIN_PULSE - 16'd1);

  coin_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    queue_q;
  logic [1:0]    queue_d;
  logic          coin_q;
  logic          deq;
  logic [2:0]    sum;

  // A coin is taken from the queue when idle, or directly at the end of a
  // gap so back-to-back pulses are spaced by exactly COIN_PULSE low cycles.
  always_comb begin
    deq     = (queue_q != 2'd0) &&
              ((state_q == IDLE) || ((state_q == GAP) && (cnt_q == CNT_LAST)));
    sum     = {1'b0, queue_q} + {1'b0, edge_cnt} - {2'b00, deq};
    queue_d = (sum > 3'(QUEUE_MAX)) ? 2'(QUEUE_MAX) : sum[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      queue_q <= 2'd0;
      coin_q  <= 1'b0;
    end else begin
      queue_q <= queue_d;
      case (state_q)
        IDLE: begin
          if (deq) begin
            state_q <= PULSE;
            cnt_q   <= '0;
            coin_q  <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= GAP;
            cnt_q   <= '0;
            coin_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (deq) begin
              state_q <= PULSE;
              coin_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          coin_q  <= 1'b0;
        end
      endcase
    end
  end

  assign coin    = coin_q;
  assign pending = queue_q;

endmodule
`default_nettype wire

// File: rtl/arcade_input_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : arcade_input_router                                           |
// | Purpose  : Routes hps_io joystick words to a core's controls: upright    |
// |            (OR of players) or cocktail (active player), SOCD cleaning,   |
// |            per-button autofire, start OR and a queued coin pulser.       |
// | Ports    : clk, reset (async, active high)                               |
// |            joystick_in   packed words, player 0 in [15:0]                |
// |            mode_cocktail 0 upright / 1 cocktail                          |
// |            active_player player driving the core in cocktail             |
// |            autofire_en   per-button autofire enable                      |
// |            btn_left/right/up/down, btn_action, btn_start  routed out     |
// |            btn_coin      shaped coin pulse                               |
// |            coin_pending  queued coins not yet pulsed                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module arcade_input_router
  import arcade_input_pkg::*;
#(
  parameter int          NUM_PLAYERS  = 2,
  parameter int          NUM_BUTTONS  = 2,
  parameter int          BTN_BASE     = 4,
  parameter int          START_BIT    = 6,
  parameter int          COIN_BIT     = 8,
  parameter logic [15:0] COIN_PULSE   = 16'd4096,
  parameter logic [19:0] AUTOFIRE_DIV = 20'd183333
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [16*NUM_PLAYERS-1:0] joystick_in,
  input  logic                      mode_cocktail,
  input  logic [1:0]                active_player,
  input  logic [NUM_BUTTONS-1:0]    autofire_en,
  output logic                      btn_left,
  output logic                      btn_right,
  output logic                      btn_up,
  output logic                      btn_down,
  output logic [NUM_BUTTONS-1:0]    btn_action,
  output logic [NUM_PLAYERS-1:0]    btn_start,
  output logic                      btn_coin,
  output logic [1:0]                coin_pending
);

  localparam int            AW      = (AUTOFIRE_DIV > 20'd1) ? $clog2(AUTOFIRE_DIV) : 1;
  localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_DIV - 20'd1);

  logic [16*NUM_PLAYERS-1:0] joy_q;
  logic [NUM_PLAYERS-1:0]    coin_prev_q;
  logic [NUM_BUTTONS-1:0]    held_q;
  logic [AW-1:0]             af_cnt_q;
  logic                      af_phase_q;
  logic                      left_q, right_q, up_q, down_q;
  logic [NUM_BUTTONS-1:0]    action_q;
  logic [NUM_PLAYERS-1:0]    start_q;

  logic [15:0]               src_or, src_sel, src;
  logic [NUM_PLAYERS-1:0]    coin_now;
  logic [NUM_PLAYERS-1:0]    start_d;
  logic [2:0]                edge_sum;
  logic [1:0]                edge_cnt;
  logic [NUM_BUTTONS-1:0]    held;
  logic [NUM_BUTTONS-1:0]    action_d;
  logic                      press;
  logic                      phase_now;
  logic [AW-1:0]             cnt_now;
  logic                      unused_bits;

  always_comb begin
    src_or   = '0;
    src_sel  = joy_q[15:0];      // out-of-range active_player falls back to player 0
    start_d  = '0;
    edge_sum = '0;
    coin_now = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      src_or |= joy_q[16*p +: 16];
      if (int'(active_player) == p) begin
        src_sel = joy_q[16*p +: 16];
      end
      coin_now[p] = joy_q[16*p + COIN_BIT];
      edge_sum    += 3'(joy_q[16*p + COIN_BIT] & ~coin_prev_q[p]);
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int w = 0; w < NUM_PLAYERS; w++) begin
        start_d[p] |= joy_q[16*w + START_BIT + p];
      end
    end
    edge_cnt = (edge_sum > 3'd3) ? 2'd3 : edge_sum[1:0];

    src  = mode_cocktail ? src_sel : src_or;
    held = src[BTN_BASE +: NUM_BUTTONS];

    // A fresh press on any autofire button restarts the shared cadence with
    // a high phase so the first shot is not delayed.
    press     = |(held & ~held_q & autofire_en);
    phase_now = press | af_phase_q;
    cnt_now   = press ? '0 : af_cnt_q;
    action_d  = held & (~autofire_en | {NUM_BUTTONS{phase_now}});
  end

  // Collects word bits this configuration does not route anywhere.
  assign unused_bits = ^{joy_q, src};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      joy_q       <= '0;
      coin_prev_q <= '0;
      held_q      <= '0;
      af_cnt_q    <= '0;
      af_phase_q  <= 1'b1;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      action_q    <= '0;
      start_q     <= '0;
    end else begin
      joy_q       <= joystick_in;
      coin_prev_q <= coin_now;
      held_q      <= held;
      if (cnt_now == AF_LAST) begin
        af_cnt_q   <= '0;
        af_phase_q <= ~phase_now;
      end else begin
        af_cnt_q   <= cnt_now + AW'(1);
        af_phase_q <= phase_now;
      end
      // Opposing directions cancel each other.
      left_q   <= src[JOY_LEFT]  & ~src[JOY_RIGHT];
      right_q  <= src[JOY_RIGHT] & ~src[JOY_LEFT];
      up_q     <= src[JOY_UP]    & ~src[JOY_DOWN];
      down_q   <= src[JOY_DOWN]  & ~src[JOY_UP];
      action_q <= action_d;
      start_q  <= start_d;
    end
  end

  coin_pulser #(
    .COIN_PULSE (COIN_PULSE)
  ) u_coin_pulser (
    .clk      (clk),
    .reset    (reset),
    .edge_cnt (edge_cnt),
    .coin     (btn_coin),
    .pending  (coin_pending)
  );

  assign btn_left   = left_q;
  assign btn_right  = right_q;
  assign btn_up     = up_q;
  assign btn_down   = down_q;
  assign btn_action = action_q;
  assign btn_start  = start_q;

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_arcade_input_router                                        |
// | Purpose  : Self-checking bench: directed scenarios plus randomized       |
// |            stimulus compared each cycle against a behavioural model.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_arcade_input_router;

  localparam int P_LEN  = 4;   // coin pulse / gap length
  localparam int AF_DIV = 3;   // autofire half-period

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] joystick_in = '0;
  logic        mode_cocktail = 1'b0;
  logic [1:0]  active_player = 2'd0;
  logic [1:0]  autofire_en = 2'd0;
  logic        btn_left, btn_right, btn_up, btn_down, btn_coin;
  logic [1:0]  btn_action, btn_start, coin_pending;

  arcade_input_router #(
    .NUM_PLAYERS  (2),
    .NUM_BUTTONS  (2),
    .BTN_BASE     (4),
    .START_BIT    (6),
    .COIN_BIT     (8),
    .COIN_PULSE   (16'd4),
    .AUTOFIRE_DIV (20'd3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .joystick_in   (joystick_in),
    .mode_cocktail (mode_cocktail),
    .active_player (active_player),
    .autofire_en   (autofire_en),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .btn_action    (btn_action),
    .btn_start     (btn_start),
    .btn_coin      (btn_coin),
    .coin_pending  (coin_pending)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: what the DUT input register holds / held one cycle earlier,
  // and the value driven last cycle (captured at the next edge).
  logic [31:0] m_cap, m_cap_prev, m_drv1;
  logic        m_mode;
  logic [1:0]  m_ap, m_af, m_held_prev;
  int          m_k;          // cycles since the autofire cadence last restarted
  int          m_pend;       // coins waiting
  int          m_next_free;  // first edge at which a new pulse may start
  int          m_pstart;     // edge at which the current/last pulse started
  int          cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] joy, input logic mode, input logic [1:0] ap,
                       input logic [1:0] af);
    joystick_in   = joy;
    mode_cocktail = mode;
    active_player = ap;
    autofire_en   = af;
  endtask

  // Async reset asserted mid-cycle; released just after an edge with new inputs.
  task automatic do_reset(input logic [31:0] joy, input logic mode, input logic [1:0] ap,
                          input logic [1:0] af);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_coin", {31'd0, btn_coin}, 32'd0);
    chk("rst_pend", {30'd0, coin_pending}, 32'd0);
    chk("rst_outs", {24'd0, btn_left, btn_right, btn_up, btn_down, btn_action, btn_start}, 32'd0);
    drive(32'd0, 1'b0, 2'd0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(joy, mode, ap, af);
    m_cap = '0; m_cap_prev = '0; m_drv1 = joy;
    m_mode = mode; m_ap = ap; m_af = af; m_held_prev = '0;
    m_k = -1; m_pend = 0; m_next_free = 0; m_pstart = -1000; cyc = 0;
  endtask

  // One clock: check the outputs produced by this edge, then drive new inputs.
  task automatic step(input logic [31:0] joy, input logic mode, input logic [1:0] ap,
                      input logic [1:0] af);
    logic [15:0] w0, w1, p0, p1, src;
    logic [1:0]  held, act, st;
    logic        press, phase, exp_coin;
    int          edges, deq;
    @(posedge clk);
    #1;
    cyc++;
    w0 = m_cap[15:0];      w1 = m_cap[31:16];
    p0 = m_cap_prev[15:0]; p1 = m_cap_prev[31:16];
    if (!m_mode)         src = w0 | w1;
    else if (m_ap == 1)  src = w1;
    else                 src = w0;
    chk("dirs", {28'd0, btn_left, btn_right, btn_up, btn_down},
        {28'd0, src[1] & !src[0], src[0] & !src[1], src[3] & !src[2], src[2] & !src[3]});

    held  = src[5:4];
    press = |(held & ~m_held_prev & m_af);
    m_k   = press ? 0 : m_k + 1;
    phase = ((m_k / AF_DIV) % 2) == 0;
    for (int b = 0; b < 2; b++) act[b] = m_af[b] ? (held[b] & phase) : held[b];
    chk("action", {30'd0, btn_action}, {30'd0, act});
    for (int p = 0; p < 2; p++) st[p] = w0[6+p] | w1[6+p];
    chk("start", {30'd0, btn_start}, {30'd0, st});

    edges = int'(w0[8] & !p0[8]) + int'(w1[8] & !p1[8]);
    deq   = (m_pend > 0 && cyc >= m_next_free) ? 1 : 0;
    if (deq == 1) begin
      m_pstart    = cyc;
      m_next_free = cyc + 2 * P_LEN;
    end
    m_pend = m_pend + edges - deq;
    if (m_pend > 3) m_pend = 3;
    exp_coin = (cyc >= m_pstart) && (cyc < m_pstart + P_LEN);
    chk("coin", {31'd0, btn_coin}, {31'd0, exp_coin});
    chk("pending", {30'd0, coin_pending}, m_pend);

    m_held_prev = held;
    m_cap_prev  = m_cap;
    m_cap       = m_drv1;
    m_drv1      = joy;
    m_mode = mode; m_ap = ap; m_af = af;
    drive(joy, mode, ap, af);
  endtask

  initial begin : main
    logic [11:0] af_pat;
    logic [31:0] rj;
    logic        rm, prev_coin;
    logic [1:0]  ra, rf;
    int          pulses, hi_len, lo_len, max_pend, highs;
    af_pat = 12'b111000111000;

    // Upright: P0 left, P1 button 0.
    do_reset(32'h0010_0002, 1'b0, 2'd0, 2'd0);
    step(32'h0010_0002, 1'b0, 2'd0, 2'd0);
    step(32'h0010_0002, 1'b0, 2'd0, 2'd0);
    chk("up_left", {31'd0, btn_left}, 32'd1);
    chk("up_act0", {31'd0, btn_action[0]}, 32'd1);

    // Cocktail: P0 left, P1 right; player 1 then out-of-range player 3.
    do_reset(32'h0001_0002, 1'b1, 2'd1, 2'd0);
    step(32'h0001_0002, 1'b1, 2'd1, 2'd0);
    step(32'h0001_0002, 1'b1, 2'd3, 2'd0);
    chk("ck_p1", {28'd0, btn_left, btn_right, btn_up, btn_down}, 32'h4);
    step(32'h0001_0002, 1'b1, 2'd3, 2'd0);
    chk("ck_p3", {28'd0, btn_left, btn_right, btn_up, btn_down}, 32'h8);

    // SOCD on both axes.
    do_reset(32'h0000_0003, 1'b0, 2'd0, 2'd0);
    step(32'h0000_000C, 1'b0, 2'd0, 2'd0);
    step(32'h0000_0000, 1'b0, 2'd0, 2'd0);
    chk("socd_lr", {30'd0, btn_left, btn_right}, 32'd0);
    step(32'h0000_0000, 1'b0, 2'd0, 2'd0);
    chk("socd_ud", {30'd0, btn_up, btn_down}, 32'd0);

    // Autofire cadence on button 0, then release and re-press.
    do_reset(32'h0000_0010, 1'b0, 2'd0, 2'b01);
    for (int j = 1; j <= 18; j++) begin
      step((j <= 11 || j >= 16) ? 32'h0000_0010 : 32'h0, 1'b0, 2'd0, 2'b01);
      if (j >= 2 && j <= 13) chk("af_seq", {31'd0, btn_action[0]}, {31'd0, af_pat[13-j]});
    end
    chk("af_repress", {31'd0, btn_action[0]}, 32'd1);

    // Coin: 5 edges in 6 cycles across both words.
    do_reset(32'h0000_0100, 1'b0, 2'd0, 2'd0);
    pulses = 0; hi_len = 0; lo_len = 0; max_pend = 0; prev_coin = 1'b0;
    for (int j = 1; j <= 45; j++) begin
      case (j)
        1, 3:    rj = 32'h0100_0000;
        2, 4:    rj = 32'h0000_0100;
        default: rj = 32'h0;
      endcase
      step(rj, 1'b0, 2'd0, 2'd0);
      if (int'(coin_pending) > max_pend) max_pend = int'(coin_pending);
      if (btn_coin && !prev_coin) begin
        if (pulses > 0) chk("coin_gap", lo_len, P_LEN);
        pulses++; hi_len = 0;
      end
      if (!btn_coin && prev_coin) begin
        chk("coin_width", hi_len, P_LEN);
        lo_len = 0;
      end
      if (btn_coin) hi_len++; else lo_len++;
      prev_coin = btn_coin;
    end
    chk("coin_pulses", pulses, 4);
    chk("coin_maxpend", max_pend, 3);

    // Reset during a pulse; nothing must follow without a new edge.
    do_reset(32'h0000_0100, 1'b0, 2'd0, 2'd0);
    for (int j = 1; j <= 4; j++) step(32'h0, 1'b0, 2'd0, 2'd0);
    chk("coin_rise", {31'd0, btn_coin}, 32'd1);
    do_reset(32'h0, 1'b0, 2'd0, 2'd0);
    highs = 0;
    for (int j = 1; j <= 20; j++) begin
      step(32'h0, 1'b0, 2'd0, 2'd0);
      if (btn_coin) highs++;
    end
    chk("post_rst_quiet", highs, 0);

    // Randomized traffic.
    do_reset(32'h0, 1'b0, 2'd0, 2'd0);
    rj = '0; rm = 1'b0; ra = 2'd0; rf = 2'd0;
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(3) == 0) rj[15:0]  = 16'($urandom);
      if ($urandom_range(3) == 0) rj[31:16] = 16'($urandom);
      if ($urandom_range(15) == 0) rm = 1'($urandom);
      if ($urandom_range(7) == 0)  ra = 2'($urandom);
      if ($urandom_range(15) == 0) rf = 2'($urandom);
      if ($urandom_range(199) == 0) do_reset(rj, rm, ra, rf);
      else step(rj, rm, ra, rf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
